arcade_input_mapper: RTL

Parametrised PS/2 keyboard and joystick input mapper for arcade cores. It is the successor to the per-core hand-coded key decoders and sits between `hps_io` and the game core. It decodes `ps2_key` events into per-player key state using a fixed MAME/JPAC keymap, merges each player's own joystick, and applies optional screen-rotation remapping. It also stretches coin presses into fixed-length pulses and drives active-low per-player control buses.

---
 rtl/arcade_input_pkg.sv | 109 ++++++++++
 rtl/arcade_input_mapper_coin.sv | 40 ++++
 rtl/arcade_input_mapper.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input mapper: PS/2 set-2 scancodes,
// joystick bit layout, direction struct and the keymap decoder.
package arcade_input_pkg;

  localparam int MAX_PLAYERS = 4;
  localparam int MAX_BUTTONS = 4;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE0 = 4;

  localparam logic [7:0] SC_P1_UP = 8'h75, SC_P1_DOWN = 8'h72, SC_P1_LEFT = 8'h6B, SC_P1_RIGHT = 8'h74;
  localparam logic [7:0] SC_P1_F0 = 8'h14, SC_P1_F1 = 8'h11, SC_P1_F2 = 8'h29, SC_P1_F3 = 8'h12;
  localparam logic [7:0] SC_P2_UP = 8'h2D, SC_P2_DOWN = 8'h2B, SC_P2_LEFT = 8'h23, SC_P2_RIGHT = 8'h34;
  localparam logic [7:0] SC_P2_F0 = 8'h1C, SC_P2_F1 = 8'h1B, SC_P2_F2 = 8'h15, SC_P2_F3 = 8'h1D;
  localparam logic [7:0] SC_P3_UP = 8'h43, SC_P3_DOWN = 8'h42, SC_P3_LEFT = 8'h3B, SC_P3_RIGHT = 8'h4B;
  localparam logic [7:0] SC_P3_F0 = 8'h1A, SC_P3_F1 = 8'h22, SC_P3_F2 = 8'h21, SC_P3_F3 = 8'h2A;
  localparam logic [7:0] SC_P4_UP = 8'h3C, SC_P4_DOWN = 8'h44, SC_P4_LEFT = 8'h35, SC_P4_RIGHT = 8'h33;
  localparam logic [7:0] SC_P4_F0 = 8'h32, SC_P4_F1 = 8'h31, SC_P4_F2 = 8'h3A, SC_P4_F3 = 8'h41;
  localparam logic [7:0] SC_START1 = 8'h16, SC_START2 = 8'h1E, SC_START3 = 8'h26, SC_START4 = 8'h25;
  localparam logic [7:0] SC_COIN1 = 8'h2E, SC_COIN2 = 8'h36, SC_COIN3 = 8'h3D, SC_COIN4 = 8'h3E;
  localparam logic [7:0] SC_F1 = 8'h05, SC_F2 = 8'h06, SC_TEST = 8'h2C;

  typedef enum logic [3:0] {
    SLOT_UP, SLOT_DOWN, SLOT_LEFT, SLOT_RIGHT,
    SLOT_FIRE, SLOT_START, SLOT_ALIAS, SLOT_COIN, SLOT_TEST
  } slot_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] player;
    slot_e      slot;
    logic [1:0] btn;
  } key_sel_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  function automatic key_sel_t key_sel(input logic [1:0] p, input slot_e s, input logic [1:0] b);
    key_sel_t k;
    k.hit    = 1'b1;
    k.player = p;
    k.slot   = s;
    k.btn    = b;
    return k;
  endfunction

  // Only the P1 arrows accept the extended prefix, so the keypad doubles as a stick.
  function automatic key_sel_t decode_key(input logic ext, input logic [7:0] sc);
    key_sel_t k;
    logic     arrow;
    arrow = 1'b0;
    case (sc)
      SC_P1_UP:    begin k = key_sel(2'd0, SLOT_UP,    2'd0); arrow = 1'b1; end
      SC_P1_DOWN:  begin k = key_sel(2'd0, SLOT_DOWN,  2'd0); arrow = 1'b1; end
      SC_P1_LEFT:  begin k = key_sel(2'd0, SLOT_LEFT,  2'd0); arrow = 1'b1; end
      SC_P1_RIGHT: begin k = key_sel(2'd0, SLOT_RIGHT, 2'd0); arrow = 1'b1; end
      SC_P1_F0:    k = key_sel(2'd0, SLOT_FIRE, 2'd0);
      SC_P1_F1:    k = key_sel(2'd0, SLOT_FIRE, 2'd1);
      SC_P1_F2:    k = key_sel(2'd0, SLOT_FIRE, 2'd2);
      SC_P1_F3:    k = key_sel(2'd0, SLOT_FIRE, 2'd3);
      SC_P2_UP:    k = key_sel(2'd1, SLOT_UP,    2'd0);
      SC_P2_DOWN:  k = key_sel(2'd1, SLOT_DOWN,  2'd0);
      SC_P2_LEFT:  k = key_sel(2'd1, SLOT_LEFT,  2'd0);
      SC_P2_RIGHT: k = key_sel(2'd1, SLOT_RIGHT, 2'd0);
      SC_P2_F0:    k = key_sel(2'd1, SLOT_FIRE, 2'd0);
      SC_P2_F1:    k = key_sel(2'd1, SLOT_FIRE, 2'd1);
      SC_P2_F2:    k = key_sel(2'd1, SLOT_FIRE, 2'd2);
      SC_P2_F3:    k = key_sel(2'd1, SLOT_FIRE, 2'd3);
      SC_P3_UP:    k = key_sel(2'd2, SLOT_UP,    2'd0);
      SC_P3_DOWN:  k = key_sel(2'd2, SLOT_DOWN,  2'd0);
      SC_P3_LEFT:  k = key_sel(2'd2, SLOT_LEFT,  2'd0);
      SC_P3_RIGHT: k = key_sel(2'd2, SLOT_RIGHT, 2'd0);
      SC_P3_F0:    k = key_sel(2'd2, SLOT_FIRE, 2'd0);
      SC_P3_F1:    k = key_sel(2'd2, SLOT_FIRE, 2'd1);
      SC_P3_F2:    k = key_sel(2'd2, SLOT_FIRE, 2'd2);
      SC_P3_F3:    k = key_sel(2'd2, SLOT_FIRE, 2'd3);
      SC_P4_UP:    k = key_sel(2'd3, SLOT_UP,    2'd0);
      SC_P4_DOWN:  k = key_sel(2'd3, SLOT_DOWN,  2'd0);
      SC_P4_LEFT:  k = key_sel(2'd3, SLOT_LEFT,  2'd0);
      SC_P4_RIGHT: k = key_sel(2'd3, SLOT_RIGHT, 2'd0);
      SC_P4_F0:    k = key_sel(2'd3, SLOT_FIRE, 2'd0);
      SC_P4_F1:    k = key_sel(2'd3, SLOT_FIRE, 2'd1);
      SC_P4_F2:    k = key_sel(2'd3, SLOT_FIRE, 2'd2);
      SC_P4_F3:    k = key_sel(2'd3, SLOT_FIRE, 2'd3);
      SC_START1:   k = key_sel(2'd0, SLOT_START, 2'd0);
      SC_START2:   k = key_sel(2'd1, SLOT_START, 2'd0);
      SC_START3:   k = key_sel(2'd2, SLOT_START, 2'd0);
      SC_START4:   k = key_sel(2'd3, SLOT_START, 2'd0);
      SC_COIN1:    k = key_sel(2'd0, SLOT_COIN, 2'd0);
      SC_COIN2:    k = key_sel(2'd1, SLOT_COIN, 2'd0);
      SC_COIN3:    k = key_sel(2'd2, SLOT_COIN, 2'd0);
      SC_COIN4:    k = key_sel(2'd3, SLOT_COIN, 2'd0);
      SC_F1:       k = key_sel(2'd0, SLOT_ALIAS, 2'd0);
      SC_F2:       k = key_sel(2'd1, SLOT_ALIAS, 2'd0);
      SC_TEST:     k = key_sel(2'd0, SLOT_TEST, 2'd0);
      default:     k = '0;
    endcase
    if (ext && !arrow) k.hit = 1'b0;
    return k;
  endfunction

endpackage

// File: rtl/arcade_input_mapper_coin.sv
// Per-player coin stretcher: a raw rising edge starts a fixed-length pulse;
// COIN_PULSE = 0 turns it into a level pass-through.
module coin_pulse_stretch #(
  parameter int COIN_PULSE = 600000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  generate
    if (COIN_PULSE == 0) begin : g_level
      logic unused_clk_rst;
      assign unused_clk_rst = clk_sys ^ reset;
      assign pulse = raw;
    end else begin : g_stretch
      localparam int CW = $clog2(COIN_PULSE + 1);
      logic [CW-1:0] cnt_reg;
      logic          raw_prev_reg;

      // Edges arriving while a pulse is running are dropped, not queued.
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          cnt_reg      <= '0;
          raw_prev_reg <= 1'b0;
        end else begin
          raw_prev_reg <= raw;
          if (raw && !raw_prev_reg && cnt_reg == '0)
            cnt_reg <= CW'(COIN_PULSE);
          else if (cnt_reg != '0)
            cnt_reg <= cnt_reg - CW'(1);
        end
      end

      assign pulse = (cnt_reg != '0);
    end
  endgenerate

endmodule

// File: rtl/arcade_input_mapper.sv
// PS/2 + joystick to active-low arcade control mapper with optional rotation.
// Build option: define INPUT_SOCD_EN for neutral opposing-direction cleaning.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int PLAYERS    = 2,
  parameter int BUTTONS    = 2,
  parameter int COIN_PULSE = 600000
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic [10:0]                ps2_key,
  input  logic [16*PLAYERS-1:0]      joystick,
  input  logic                       rotate,
  output logic [PLAYERS-1:0]         o_up_n,
  output logic [PLAYERS-1:0]         o_down_n,
  output logic [PLAYERS-1:0]         o_left_n,
  output logic [PLAYERS-1:0]         o_right_n,
  output logic [BUTTONS*PLAYERS-1:0] o_fire_n,
  output logic [PLAYERS-1:0]         o_start_n,
  output logic [PLAYERS-1:0]         o_coin_n,
  output logic                       o_test_n
);

  logic     old_toggle_reg;
  logic     key_load;
  logic     key_pressed;
  key_sel_t sel;
  logic     key_test_reg;
  logic     unused_joy;

  logic [PLAYERS-1:0]         up_w, down_w, left_w, right_w, start_w, coin_w;
  logic [BUTTONS*PLAYERS-1:0] fire_w;

  assign sel         = decode_key(ps2_key[8], ps2_key[7:0]);
  assign key_pressed = ps2_key[9];
  assign key_load    = (ps2_key[10] != old_toggle_reg) && sel.hit;
  assign unused_joy  = ^joystick;

  // Tracking the toggle through reset too means a stale toggle never fires an event.
  always_ff @(posedge clk_sys) begin
    old_toggle_reg <= ps2_key[10];
  end

  always_ff @(posedge clk_sys) begin
    if (reset)
      key_test_reg <= 1'b0;
    else if (key_load && sel.slot == SLOT_TEST)
      key_test_reg <= key_pressed;
  end

  genvar gi;
  generate
    for (gi = 0; gi < PLAYERS; gi++) begin : g_player
      dir_t               key_dir_reg;
      logic [BUTTONS-1:0] key_fire_reg;
      logic               key_start_reg, key_alias_reg, key_coin_reg;
      logic               sel_here, coin_raw;
      dir_t               raw_dir, rot_dir, fin_dir;

      assign sel_here = key_load && (sel.player == 2'(gi));

      always_ff @(posedge clk_sys) begin
        if (reset) begin
          key_dir_reg   <= '0;
          key_fire_reg  <= '0;
          key_start_reg <= 1'b0;
          key_alias_reg <= 1'b0;
          key_coin_reg  <= 1'b0;
        end else if (sel_here) begin
          case (sel.slot)
            SLOT_UP:    key_dir_reg.up    <= key_pressed;
            SLOT_DOWN:  key_dir_reg.down  <= key_pressed;
            SLOT_LEFT:  key_dir_reg.left  <= key_pressed;
            SLOT_RIGHT: key_dir_reg.right <= key_pressed;
            SLOT_START: key_start_reg     <= key_pressed;
            SLOT_ALIAS: key_alias_reg     <= key_pressed;
            SLOT_COIN:  key_coin_reg      <= key_pressed;
            SLOT_FIRE: begin
              for (int b = 0; b < BUTTONS; b++)
                if (sel.btn == 2'(b)) key_fire_reg[b] <= key_pressed;
            end
            default: ;
          endcase
        end
      end

      always_comb begin
        raw_dir.up    = key_dir_reg.up    | joystick[16*gi + JOY_UP];
        raw_dir.down  = key_dir_reg.down  | joystick[16*gi + JOY_DOWN];
        raw_dir.left  = key_dir_reg.left  | joystick[16*gi + JOY_LEFT];
        raw_dir.right = key_dir_reg.right | joystick[16*gi + JOY_RIGHT];
        rot_dir = raw_dir;
        if (rotate) begin
          rot_dir.up    = raw_dir.left;
          rot_dir.down  = raw_dir.right;
          rot_dir.left  = raw_dir.down;
          rot_dir.right = raw_dir.up;
        end
`ifdef INPUT_SOCD_EN
        fin_dir.up    = rot_dir.up    & ~rot_dir.down;
        fin_dir.down  = rot_dir.down  & ~rot_dir.up;
        fin_dir.left  = rot_dir.left  & ~rot_dir.right;
        fin_dir.right = rot_dir.right & ~rot_dir.left;
`else
        fin_dir = rot_dir;
`endif
      end

      assign up_w[gi]    = fin_dir.up;
      assign down_w[gi]  = fin_dir.down;
      assign left_w[gi]  = fin_dir.left;
      assign right_w[gi] = fin_dir.right;
      assign fire_w[gi*BUTTONS +: BUTTONS] = key_fire_reg | joystick[16*gi + JOY_FIRE0 +: BUTTONS];
      assign start_w[gi] = key_start_reg | key_alias_reg | joystick[16*gi + JOY_FIRE0 + BUTTONS];
      assign coin_raw    = key_coin_reg | joystick[16*gi + JOY_FIRE0 + BUTTONS + 1];

      coin_pulse_stretch #(
        .COIN_PULSE (COIN_PULSE)
      ) u_coin (
        .clk_sys (clk_sys),
        .reset   (reset),
        .raw     (coin_raw),
        .pulse   (coin_w[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      o_up_n    <= '1;
      o_down_n  <= '1;
      o_left_n  <= '1;
      o_right_n <= '1;
      o_fire_n  <= '1;
      o_start_n <= '1;
      o_coin_n  <= '1;
      o_test_n  <= 1'b1;
    end else begin
      o_up_n    <= ~up_w;
      o_down_n  <= ~down_w;
      o_left_n  <= ~left_w;
      o_right_n <= ~right_w;
      o_fire_n  <= ~fire_w;
      o_start_n <= ~start_w;
      o_coin_n  <= ~coin_w;
      o_test_n  <= ~key_test_reg;
    end
  end

endmodule
